// File: rtl/reg_bank_sched_if.sv
// reg_bank_sched_if: read/write request-ack handshakes and registered bank controls (bank_data stays a plain inout)
interface reg_bank_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              rd_req, rd_two, rd_ack, wr_req, wr_ack;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr, bank_address;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data;
    logic              bank_trigger, bank_we, bank_oe;
    modport master (
        output rd_req, rd_two, rd_addr_a, rd_addr_b, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data_a, rd_data_b, wr_ack, bank_trigger, bank_address, bank_we, bank_oe
    );
    modport slave (
        input  rd_req, rd_two, rd_addr_a, rd_addr_b, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data_a, rd_data_b, wr_ack, bank_trigger, bank_address, bank_we, bank_oe
    );
endinterface

// File: rtl/reg_bank_sched.sv
// reg_bank_sched: serialises operand reads and writeback onto the single-ported bank (clk, async reset, bus slave, inout bank_data)
module reg_bank_sched #(
    parameter int ACCESS_CYCLES = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    reg_bank_sched_if.slave   bus,
    inout  wire  [DATA_W-1:0] bank_data
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, ACK} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              last_wr, last_wr_n, two, two_n;
    logic [ADDR_W-1:0] wa, wa_n, ra, ra_n, rb, rb_n, addr_n;
    logic [DATA_W-1:0] wd, wd_n;
    logic              done, grant, hazard, pick_wr, we_n, oe_n, trig_n;
    assign bank_data = bus.bank_we ? wd : 'z;
    always_comb begin
        done    = cnt == CW'(ACCESS_CYCLES - 1);
        hazard  = bus.wr_addr == bus.rd_addr_a || (bus.rd_two && bus.wr_addr == bus.rd_addr_b);
        pick_wr = bus.wr_req && (!bus.rd_req || hazard || !last_wr);
        grant   = state == IDLE && (bus.wr_req || bus.rd_req);
        state_n = state;
        case (state)
            IDLE:    state_n = grant ? (pick_wr ? WR : RD_A) : IDLE;
            WR:      state_n = done ? ACK : WR;
            RD_A:    state_n = done ? (two ? RD_B : ACK) : RD_A;
            RD_B:    state_n = done ? ACK : RD_B;
            default: state_n = IDLE;
        endcase
        cnt_n     = (state == IDLE || state == ACK || done) ? '0 : cnt + CW'(1);
        last_wr_n = grant ? pick_wr : last_wr;
        two_n     = grant ? bus.rd_two : two;
        wa_n      = grant ? bus.wr_addr : wa;
        wd_n      = grant ? bus.wr_data : wd;
        ra_n      = grant ? bus.rd_addr_a : ra;
        rb_n      = grant ? bus.rd_addr_b : rb;
        we_n      = state_n == WR;
        oe_n      = state_n == RD_A || state_n == RD_B;
        addr_n    = state_n == WR ? wa_n : state_n == RD_A ? ra_n : state_n == RD_B ? rb_n : '0;
        trig_n    = bus.bank_trigger ^ (state_n != state && (we_n || oe_n));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            last_wr          <= 1'b0;
            two              <= 1'b0;
            wa               <= '0;
            wd               <= '0;
            ra               <= '0;
            rb               <= '0;
            bus.bank_we      <= 1'b0;
            bus.bank_oe      <= 1'b0;
            bus.bank_address <= '0;
            bus.bank_trigger <= 1'b0;
            bus.wr_ack       <= 1'b0;
            bus.rd_ack       <= 1'b0;
            bus.rd_data_a    <= '0;
            bus.rd_data_b    <= '0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            last_wr          <= last_wr_n;
            two              <= two_n;
            wa               <= wa_n;
            wd               <= wd_n;
            ra               <= ra_n;
            rb               <= rb_n;
            bus.bank_we      <= we_n;
            bus.bank_oe      <= oe_n;
            bus.bank_address <= addr_n;
            bus.bank_trigger <= trig_n;
            bus.wr_ack       <= state_n == ACK && last_wr_n;
            bus.rd_ack       <= state_n == ACK && !last_wr_n;
            bus.rd_data_a    <= (state == RD_A && done) ? bank_data : bus.rd_data_a;
            bus.rd_data_b    <= (state == RD_B && done) ? bank_data : bus.rd_data_b;
        end
    end
endmodule

// File: tb/tb_reg_bank_sched.sv
// tb_reg_bank_sched: directed self-checking bench for reg_bank_sched with a behavioural bank model
module tb_reg_bank_sched;
    logic clk = 1'b0;
    logic reset = 1'b0;
    wire [31:0] bank_data;
    int tests = 0;
    int fails = 0;
    int viol = 0;
    logic [31:0] mem [16];
    logic [15:0] mask;
    logic t0;

    reg_bank_sched_if #(.DATA_W(32), .ADDR_W(4)) bus ();
    reg_bank_sched #(.ACCESS_CYCLES(2), .DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .bank_data(bank_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [3:0] a);
        return a == 4'd15 ? 32'hFFFF_FFFF : {28'd0, a} * 32'h11;
    endfunction

    wire [31:0] rd_val = mask[bus.bank_address] ? mem[bus.bank_address] : dflt(bus.bank_address);
    assign bank_data = bus.bank_oe ? rd_val : 'z;

    always @(posedge clk or posedge reset)
        if (reset) mask <= '0;
        else if (bus.bank_we) begin
            mem[bus.bank_address]  <= bank_data;
            mask[bus.bank_address] <= 1'b1;
        end

    always @(posedge clk) begin
        if (bus.bank_we && bus.bank_oe) viol++;
        assert (!(bus.bank_we && bus.bank_oe)) else $error("bank_we and bank_oe both high");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++; if (bus.bank_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bus.bank_we); end
        tests++; if (bus.bank_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b want 0", bus.bank_oe); end
        tests++; if (bus.bank_address !== 4'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", bus.bank_address); end
        tests++; if (bus.bank_trigger !== 1'b0) begin fails++; $display("FAIL reset_trig got %b want 0", bus.bank_trigger); end
        tests++; if ({bus.rd_ack, bus.wr_ack} !== 2'b00) begin fails++; $display("FAIL reset_acks got %b want 00", {bus.rd_ack, bus.wr_ack}); end
        tests++; if ({bus.rd_data_a, bus.rd_data_b} !== 64'd0) begin fails++; $display("FAIL reset_rdata got %h want 0", {bus.rd_data_a, bus.rd_data_b}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read_two();
        t0 = bus.bank_trigger;
        bus.rd_req = 1'b1; bus.rd_two = 1'b1; bus.rd_addr_a = 4'd1; bus.rd_addr_b = 4'd15;
        for (int c = 1; c <= 5; c++) begin
            tick();
            tests++; if (bus.bank_oe !== (c <= 4)) begin fails++; $display("FAIL rd2_oe c%0d got %b want %b", c, bus.bank_oe, c <= 4); end
            tests++; if (bus.bank_we !== 1'b0) begin fails++; $display("FAIL rd2_we c%0d got %b want 0", c, bus.bank_we); end
            tests++; if (bus.bank_address !== (c <= 2 ? 4'd1 : c <= 4 ? 4'd15 : 4'd0)) begin fails++; $display("FAIL rd2_addr c%0d got %0d", c, bus.bank_address); end
            tests++; if (bus.bank_trigger !== (c <= 2 ? ~t0 : t0)) begin fails++; $display("FAIL rd2_trig c%0d got %b", c, bus.bank_trigger); end
            tests++; if (bus.rd_ack !== (c == 5)) begin fails++; $display("FAIL rd2_ack c%0d got %b want %b", c, bus.rd_ack, c == 5); end
            if (c == 1) bus.rd_addr_a = 4'd7;
        end
        tests++; if (bus.rd_data_a !== 32'h11) begin fails++; $display("FAIL rd2_data_a got %h want 00000011", bus.rd_data_a); end
        tests++; if (bus.rd_data_b !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rd2_data_b got %h want ffffffff", bus.rd_data_b); end
        bus.rd_req = 1'b0; bus.rd_two = 1'b0;
        tick();
        tests++; if (bus.rd_ack !== 1'b0) begin fails++; $display("FAIL rd2_ack_pulse got %b want 0", bus.rd_ack); end
    endtask

    task automatic test_hazard();
        bus.wr_req = 1'b1; bus.wr_addr = 4'd10; bus.wr_data = 32'd5;
        bus.rd_req = 1'b1; bus.rd_two = 1'b0; bus.rd_addr_a = 4'd10;
        for (int c = 1; c <= 7; c++) begin
            tick();
            tests++; if (bus.bank_we !== (c <= 2)) begin fails++; $display("FAIL haz_we c%0d got %b want %b", c, bus.bank_we, c <= 2); end
            tests++; if (bus.bank_oe !== (c == 5 || c == 6)) begin fails++; $display("FAIL haz_oe c%0d got %b", c, bus.bank_oe); end
            tests++; if (bus.wr_ack !== (c == 3)) begin fails++; $display("FAIL haz_wr_ack c%0d got %b", c, bus.wr_ack); end
            tests++; if (bus.rd_ack !== (c == 7)) begin fails++; $display("FAIL haz_rd_ack c%0d got %b", c, bus.rd_ack); end
            if (c == 3) bus.wr_req = 1'b0;
        end
        tests++; if (bus.rd_data_a !== 32'd5) begin fails++; $display("FAIL haz_data got %h want 00000005", bus.rd_data_a); end
        bus.rd_req = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        bus.wr_req = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'h333;
        for (int c = 1; c <= 3; c++) tick();
        tests++; if (bus.wr_ack !== 1'b1) begin fails++; $display("FAIL fair_pre_ack got %b want 1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        tick();
        bus.wr_req = 1'b1; bus.wr_data = 32'h3;
        bus.rd_req = 1'b1; bus.rd_two = 1'b0; bus.rd_addr_a = 4'd4;
        for (int c = 1; c <= 11; c++) begin
            tick();
            tests++; if (bus.bank_oe !== (c == 1 || c == 2 || c == 9 || c == 10)) begin fails++; $display("FAIL fair_oe c%0d got %b", c, bus.bank_oe); end
            tests++; if (bus.bank_we !== (c == 5 || c == 6)) begin fails++; $display("FAIL fair_we c%0d got %b", c, bus.bank_we); end
            tests++; if (bus.wr_ack !== (c == 7)) begin fails++; $display("FAIL fair_wr_ack c%0d got %b", c, bus.wr_ack); end
            tests++; if (bus.rd_ack !== (c == 3 || c == 11)) begin fails++; $display("FAIL fair_rd_ack c%0d got %b", c, bus.rd_ack); end
            if (c == 3 || c == 11) begin
                tests++; if (bus.rd_data_a !== 32'h44) begin fails++; $display("FAIL fair_data c%0d got %h want 00000044", c, bus.rd_data_a); end
                bus.rd_req = 1'b0;
            end
            if (c == 4) bus.rd_req = 1'b1;
            if (c == 7) bus.wr_req = 1'b0;
        end
        tick();
    endtask

    task automatic test_write();
        t0 = bus.bank_trigger;
        bus.wr_req = 1'b1; bus.wr_addr = 4'd10; bus.wr_data = 32'd5;
        for (int c = 1; c <= 4; c++) begin
            tick();
            tests++; if (bus.bank_we !== (c <= 2)) begin fails++; $display("FAIL wr_we c%0d got %b want %b", c, bus.bank_we, c <= 2); end
            tests++; if (bus.bank_oe !== 1'b0) begin fails++; $display("FAIL wr_oe c%0d got %b want 0", c, bus.bank_oe); end
            tests++; if (bus.wr_ack !== (c == 3)) begin fails++; $display("FAIL wr_ack c%0d got %b want %b", c, bus.wr_ack, c == 3); end
            tests++; if (bus.bank_trigger !== (c <= 3 ? ~t0 : ~t0)) begin fails++; $display("FAIL wr_trig c%0d got %b", c, bus.bank_trigger); end
            if (c <= 2) begin
                tests++; if (bus.bank_address !== 4'd10) begin fails++; $display("FAIL wr_addr c%0d got %0d want 10", c, bus.bank_address); end
                tests++; if (bank_data !== 32'd5) begin fails++; $display("FAIL wr_data c%0d got %h want 00000005", c, bank_data); end
            end
            if (c == 1) bus.wr_data = 32'd9;
            if (c == 3) bus.wr_req = 1'b0;
        end
    endtask

    task automatic test_ack_hold();
        bus.wr_req = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h55;
        for (int c = 1; c <= 7; c++) begin
            tick();
            tests++; if (bus.bank_we !== (c == 1 || c == 2 || c == 5 || c == 6)) begin fails++; $display("FAIL hold_we c%0d got %b", c, bus.bank_we); end
            tests++; if (bus.wr_ack !== (c == 3 || c == 7)) begin fails++; $display("FAIL hold_ack c%0d got %b", c, bus.wr_ack); end
        end
        bus.wr_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.rd_req = 1'b1; bus.rd_two = 1'b1; bus.rd_addr_a = 4'd1; bus.rd_addr_b = 4'd15;
        for (int c = 1; c <= 3; c++) tick();
        tests++; if (bus.bank_oe !== 1'b1 || bus.bank_address !== 4'd15) begin fails++; $display("FAIL mid_rdb got oe=%b addr=%0d want 1/15", bus.bank_oe, bus.bank_address); end
        reset = 1'b1;
        #1;
        tests++; if ({bus.bank_we, bus.bank_oe, bus.bank_trigger} !== 3'b000) begin fails++; $display("FAIL mid_ctrl got %b want 000", {bus.bank_we, bus.bank_oe, bus.bank_trigger}); end
        tests++; if (bus.bank_address !== 4'd0) begin fails++; $display("FAIL mid_addr got %0d want 0", bus.bank_address); end
        tests++; if (bus.rd_data_a !== 32'd0) begin fails++; $display("FAIL mid_rdata got %h want 0", bus.rd_data_a); end
        bus.rd_req = 1'b0; bus.rd_two = 1'b0;
        tick();
        tests++; if (bus.rd_ack !== 1'b0) begin fails++; $display("FAIL mid_rd_ack got %b want 0", bus.rd_ack); end
        tick();
        reset = 1'b0;
        tick();
        bus.wr_req = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 32'd7;
        for (int c = 1; c <= 3; c++) begin
            tick();
            tests++; if (bus.bank_we !== (c <= 2)) begin fails++; $display("FAIL mid_wr_we c%0d got %b", c, bus.bank_we); end
            tests++; if (bus.wr_ack !== (c == 3)) begin fails++; $display("FAIL mid_wr_ack c%0d got %b", c, bus.wr_ack); end
            if (c <= 2) begin
                tests++; if (bus.bank_address !== 4'd2 || bank_data !== 32'd7) begin fails++; $display("FAIL mid_wr_bus c%0d got %0d/%h want 2/7", c, bus.bank_address, bank_data); end
            end
        end
        bus.wr_req = 1'b0;
        tick();
    endtask

    task automatic test_invariant();
        tests++; if (viol !== 0) begin fails++; $display("FAIL we_oe_exclusive got %0d overlaps want 0", viol); end
    endtask

    initial begin
        bus.rd_req = 1'b0; bus.rd_two = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        test_reset();
        test_read_two();
        test_hazard();
        test_fairness();
        test_write();
        test_ack_hold();
        test_reset_mid();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
